uart_top: RTL and testbench
===========================

Name: uart_top

Overview:
- Memory-mapped UART peripheral with CRC-8 protected frames.
- Each serial frame carries one data byte followed by its CRC-8 byte.
- Host access is via a simple chip-select/write-enable register bus.
- Raises RX, TX and error interrupts; sits between the system register bus and the serial pins.

Parameters:
- DIV_RST, 16'd10416, reset value of baud divisor (bit period = DIV+1 clocks; 9600 bps at 100 MHz)
- CRC_POLY, 8'h07, CRC-8 polynomial (x^8+x^2+x+1), init 8'h00, no reflection, no final XOR

Ports:
- clk  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- rx_i  in  1  serial input, idle high
- tx_o  out  1  serial output, idle high
- rx_int_o  out  1  level, high while RX data valid
- tx_int_o  out  1  level, high while TX done flag set
- err_int_o  out  1  level, high while any error flag set
- cfg_we  in  1  write enable (qualified by cfg_cs)
- cfg_cs  in  1  register select
- cfg_data_i  in  32  write data
- cfg_data_o  out  32  read data
- cfg_addr_i  in  5  register address

Behaviour:
- Single clock domain (clk); rst_i is synchronous and active-high.
- Reset values:
  - tx_o=1; all interrupts 0; cfg_data_o=0
  - DIV=DIV_RST; rx_en=0, tx_en=0, crc_en=0
  - all flags 0; FSMs IDLE
- Frame format (18 bits total): start(0), 8 data bits LSB first, 8 CRC bits LSB first, stop(1).
- Register map (word addresses):
  - 0x00 CFG (R/W): [31:16] DIV, [2] crc_en, [1] tx_en, [0] rx_en.
  - 0x01 CMD (W): bit0=1 starts TX if tx_en and not busy, else ignored. Reads 0.
  - 0x02 TX_DATA (R/W): [7:0] byte to send.
  - 0x03 RX_DATA (R): [7:0] last received byte, [15:8] last received CRC byte. Read clears rx_valid.
  - 0x04 STATUS (R / W1C): bit0 rx_valid, bit1 tx_busy, bit2 crc_err, bit3 frame_err, bit4 overrun, bit5 tx_done. Writing 1 clears bits 2-5.
  - Other addresses read 0; writes to them are ignored.
- Bus timing:
  - Write takes effect on the clk edge where cfg_cs&cfg_we.
  - Read data is registered: cfg_data_o is valid the cycle after cfg_cs&!cfg_we and holds until the next read.
  - The RX_DATA read-clear occurs on that same edge.
- RX path:
  - rx_i passes through a 2-FF synchronizer.
  - FSM states: IDLE -> START -> DATA(16 bits) -> STOP -> IDLE.
  - A falling edge in IDLE (with rx_en) enters START. rx is sampled after (DIV+1)/2 clocks; if high, the start is a glitch and the FSM returns to IDLE.
  - Each subsequent bit is sampled every DIV+1 clocks at mid-bit.
  - STOP sample = 0 sets frame_err.
  - At end of STOP, RX_DATA is loaded (data and CRC) and rx_valid is set. This happens even when an error is flagged.
  - If crc_en and received CRC != CRC8(data), crc_err is set.
  - Completion while rx_valid=1 sets overrun; the new data overwrites.
  - Completion and RX_DATA read in the same cycle: new data wins, rx_valid stays 1.
  - Clearing rx_en aborts an in-progress frame to IDLE.
- TX path:
  - FSM states: IDLE -> START -> DATA(16) -> STOP -> IDLE. Each bit lasts DIV+1 clocks.
  - CRC8(TX_DATA) is computed at start. CRC bits are always sent; if crc_en=0, 8'h00 is sent in the CRC field.
  - tx_busy is high from the start command to the end of STOP; tx_done is set at the end of STOP.
  - A CMD write while busy is ignored. A TX_DATA write while busy does not affect the current frame.
- Interrupts: rx_int_o=rx_valid; tx_int_o=tx_done; err_int_o=crc_err|frame_err|overrun.
- Changing DIV mid-frame takes effect at the next bit boundary.
- Reset mid-frame returns both FSMs to IDLE immediately and drives tx_o=1.

Test Plan:
- Reset, write CFG=0x28B00007 (DIV=10416, all enables). Drive RX frame data 0x55 / CRC 0xAC at 10417 clk/bit. Read addr 3 -> cfg_data_o[7:0]=0x55, [15:8]=0xAC; rx_int_o high before the read, low after; err_int_o=0.
- RX frame data 0x01 / CRC 0x06 (correct CRC is 0x07) -> RX_DATA[7:0]=0x01, STATUS bit2=1, err_int_o=1. Write STATUS=0x04 -> err_int_o=0.
- RX frame with stop bit driven 0 -> frame_err set. Two frames without an intervening read -> overrun set; RX_DATA holds the second byte.
- Write TX_DATA=0x55, CMD=1 -> tx_o shows 0, then 1,0,1,0,1,0,1,0, then CRC 0xAC LSB-first (0,0,1,1,0,1,0,1), then 1; each bit 10417 clocks; tx_int_o rises after stop.
- 1-clock low glitch on idle rx_i -> no frame, rx_valid stays 0. Assert rst_i mid-TX -> tx_o=1 on the next edge, STATUS=0.

Source files
------------

// File: rtl/uart_top.sv
// -----------------------------------------------------------------------------
// uart_top
// Memory-mapped UART peripheral. Each serial frame carries one data byte
// followed by its CRC-8 byte, giving 18 bits on the wire:
//    start(0), data[7:0] LSB first, crc[7:0] LSB first, stop(1).
// Bit period is DIV+1 clocks. DIV is sampled at every bit boundary, so a
// change made mid-frame takes effect at the next bit.
//
// Ports:
//    clk         system clock
//    rst_i       synchronous active-high reset
//    rx_i        serial input, idle high
//    tx_o        serial output, idle high
//    rx_int_o    level, high while RX data valid
//    tx_int_o    level, high while TX done flag set
//    err_int_o   level, high while any error flag set
//    cfg_cs      register select
//    cfg_we      write enable (qualified by cfg_cs)
//    cfg_addr_i  register word address
//    cfg_data_i  write data
//    cfg_data_o  registered read data, valid the cycle after a read
//
// Register map (word addresses):
//    0x00 CFG     R/W  [31:16] DIV, [2] crc_en, [1] tx_en, [0] rx_en
//    0x01 CMD     W    bit0=1 starts TX when tx_en and idle; reads 0
//    0x02 TX_DATA R/W  [7:0] byte to send
//    0x03 RX_DATA R    [7:0] data, [15:8] CRC; read clears rx_valid
//    0x04 STATUS  R/W1C bit0 rx_valid, bit1 tx_busy, bit2 crc_err,
//                      bit3 frame_err, bit4 overrun, bit5 tx_done
// -----------------------------------------------------------------------------
module uart_top #(
   parameter logic [15:0] DIV_RST  = 16'd10416,
   parameter logic [7:0]  CRC_POLY = 8'h07
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        rx_i,
   output logic        tx_o,
   output logic        rx_int_o,
   output logic        tx_int_o,
   output logic        err_int_o,
   input  logic        cfg_we,
   input  logic        cfg_cs,
   input  logic [31:0] cfg_data_i,
   output logic [31:0] cfg_data_o,
   input  logic [4:0]  cfg_addr_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic [4:0] A_CFG    = 5'h00;
   localparam logic [4:0] A_CMD    = 5'h01;
   localparam logic [4:0] A_TXDATA = 5'h02;
   localparam logic [4:0] A_RXDATA = 5'h03;
   localparam logic [4:0] A_STATUS = 5'h04;

   // CRC-8, MSB-first, init 0, no reflection, no final XOR.
   function automatic logic [7:0] crc8(input logic [7:0] d);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
      end
      return c;
   endfunction

   // ---------------------------------------------------------------------------
   // Register state
   // ---------------------------------------------------------------------------
   logic [15:0] div;
   logic        rx_en, tx_en, crc_en;
   logic [7:0]  tx_data;
   logic [7:0]  rx_data, rx_crc;
   logic        rx_valid, crc_err, frame_err, overrun, tx_done;
   logic        tx_busy;

   // Bus decode
   logic wr, rd;
   logic wr_cfg, wr_txd, wr_sts, rd_rxd;
   logic tx_start;

   assign wr     = cfg_cs & cfg_we;
   assign rd     = cfg_cs & ~cfg_we;
   assign wr_cfg = wr && (cfg_addr_i == A_CFG);
   assign wr_txd = wr && (cfg_addr_i == A_TXDATA);
   assign wr_sts = wr && (cfg_addr_i == A_STATUS);
   assign rd_rxd = rd && (cfg_addr_i == A_RXDATA);

   // Data bits 15:8 of a write never land in any register.
   logic unused_wdata;
   assign unused_wdata = &{1'b0, cfg_data_i[15:8]};

   // ---------------------------------------------------------------------------
   // RX path
   // ---------------------------------------------------------------------------
   state_t      rx_state, rx_next;
   logic        rx_meta, rx_sync, rx_prev;
   logic [15:0] rx_cnt, rx_bit_div;
   logic [3:0]  rx_idx;
   logic [15:0] rx_shift;
   logic        rx_fall, rx_half, rx_tick, rx_done;

   // RX state register
   always_ff @(posedge clk) begin
      // NOTE: synchronous reset -- rst_i is only looked at on the clock edge,
      // so it must be held for at least one rising edge to take effect.
      if (rst_i) rx_state <= S_IDLE;
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      else       rx_state <= rx_next;
   end

   // RX next-state logic
   always_comb begin
      // NOTE: default assignment first so no path leaves rx_next unassigned,
      // which would otherwise infer a latch.
      rx_next = rx_state;
      unique case (rx_state)
         S_IDLE:  if (rx_en && rx_fall) rx_next = S_START;
         // A start bit that is high again at mid-bit was a glitch.
         S_START: if (rx_half) rx_next = rx_sync ? S_IDLE : S_DATA;
         S_DATA:  if (rx_tick && (rx_idx == 4'd15)) rx_next = S_STOP;
         S_STOP:  if (rx_tick) rx_next = S_IDLE;
         default: rx_next = S_IDLE;
      endcase
      if (!rx_en) rx_next = S_IDLE;
   end

   // RX output/strobe logic
   always_comb begin
      rx_fall = rx_prev & ~rx_sync;
      rx_half = (rx_cnt == {1'b0, rx_bit_div[15:1]});
      rx_tick = (rx_cnt == rx_bit_div);
      rx_done = rx_en && (rx_state == S_STOP) && rx_tick;
   end

   // RX synchronizer, bit timing and shift register
   always_ff @(posedge clk) begin
      if (rst_i) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_cnt     <= '0;
         rx_bit_div <= DIV_RST;
         rx_idx     <= '0;
         rx_shift   <= '0;
      end else begin
         rx_meta <= rx_i;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         unique case (rx_state)
            S_IDLE: begin
               rx_cnt     <= '0;
               rx_idx     <= '0;
               rx_bit_div <= div;
            end
            S_START: begin
               if (rx_half) begin
                  rx_cnt     <= '0;
                  rx_bit_div <= div;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (rx_tick) begin
                  rx_cnt     <= '0;
                  rx_bit_div <= div;
                  rx_idx     <= rx_idx + 4'd1;
                  // LSB-first: data ends up in [7:0], CRC in [15:8].
                  rx_shift   <= {rx_sync, rx_shift[15:1]};
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (rx_tick) rx_cnt <= '0;
               else         rx_cnt <= rx_cnt + 16'd1;
            end
            default: rx_cnt <= '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // TX path
   // ---------------------------------------------------------------------------
   state_t      tx_state, tx_next;
   logic [15:0] tx_cnt, tx_bit_div;
   logic [3:0]  tx_idx;
   logic [15:0] tx_shift;
   logic        tx_tick, tx_end;

   assign tx_start = wr && (cfg_addr_i == A_CMD) && cfg_data_i[0] && tx_en
                     && (tx_state == S_IDLE);

   // TX state register
   always_ff @(posedge clk) begin
      if (rst_i) tx_state <= S_IDLE;
      else       tx_state <= tx_next;
   end

   // TX next-state logic
   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         S_IDLE:  if (tx_start) tx_next = S_START;
         S_START: if (tx_tick) tx_next = S_DATA;
         S_DATA:  if (tx_tick && (tx_idx == 4'd15)) tx_next = S_STOP;
         S_STOP:  if (tx_tick) tx_next = S_IDLE;
         default: tx_next = S_IDLE;
      endcase
   end

   // TX output logic
   always_comb begin
      tx_tick = (tx_cnt == tx_bit_div);
      tx_end  = (tx_state == S_STOP) && tx_tick;
      tx_busy = (tx_state != S_IDLE);
      unique case (tx_state)
         S_START: tx_o = 1'b0;
         S_DATA:  tx_o = tx_shift[0];
         default: tx_o = 1'b1;
      endcase
   end

   // TX bit timing and shift register. The frame is captured at the start
   // command, so later TX_DATA writes do not disturb it.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         tx_cnt     <= '0;
         tx_bit_div <= DIV_RST;
         tx_idx     <= '0;
         tx_shift   <= '0;
      end else begin
         unique case (tx_state)
            S_IDLE: begin
               tx_cnt <= '0;
               tx_idx <= '0;
               if (tx_start) begin
                  tx_bit_div <= div;
                  tx_shift   <= {(crc_en ? crc8(tx_data) : 8'h00), tx_data};
               end
            end
            S_START: begin
               if (tx_tick) begin
                  tx_cnt     <= '0;
                  tx_bit_div <= div;
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (tx_tick) begin
                  tx_cnt     <= '0;
                  tx_bit_div <= div;
                  tx_idx     <= tx_idx + 4'd1;
                  tx_shift   <= {1'b0, tx_shift[15:1]};
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (tx_tick) tx_cnt <= '0;
               else         tx_cnt <= tx_cnt + 16'd1;
            end
            default: tx_cnt <= '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Registers, flags and read port
   // ---------------------------------------------------------------------------
   logic [31:0] rd_mux;
   logic        set_crc, set_frame, set_ovr;
   logic [5:0]  w1c;

   always_comb begin
      set_crc   = rx_done && crc_en && (rx_shift[15:8] != crc8(rx_shift[7:0]));
      set_frame = rx_done && !rx_sync;
      set_ovr   = rx_done && rx_valid;
      w1c       = wr_sts ? cfg_data_i[5:0] : 6'd0;
   end

   always_comb begin
      rd_mux = 32'd0;
      unique case (cfg_addr_i)
         A_CFG:    rd_mux = {div, 13'd0, crc_en, tx_en, rx_en};
         A_TXDATA: rd_mux = {24'd0, tx_data};
         A_RXDATA: rd_mux = {16'd0, rx_crc, rx_data};
         A_STATUS: rd_mux = {26'd0, tx_done, overrun, frame_err, crc_err,
                             tx_busy, rx_valid};
         default:  rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         div        <= DIV_RST;
         rx_en      <= 1'b0;
         tx_en      <= 1'b0;
         crc_en     <= 1'b0;
         tx_data    <= '0;
         rx_data    <= '0;
         rx_crc     <= '0;
         rx_valid   <= 1'b0;
         crc_err    <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         tx_done    <= 1'b0;
         cfg_data_o <= '0;
      end else begin
         if (wr_cfg) begin
            div    <= cfg_data_i[31:16];
            crc_en <= cfg_data_i[2];
            tx_en  <= cfg_data_i[1];
            rx_en  <= cfg_data_i[0];
         end
         if (wr_txd) tx_data <= cfg_data_i[7:0];

         // Completion wins over a same-cycle RX_DATA read.
         if (rx_done) begin
            rx_data  <= rx_shift[7:0];
            rx_crc   <= rx_shift[15:8];
            rx_valid <= 1'b1;
         end else if (rd_rxd) begin
            rx_valid <= 1'b0;
         end

         // A flag being set in the same cycle as its W1C stays set.
         crc_err   <= (crc_err   & ~w1c[2]) | set_crc;
         frame_err <= (frame_err & ~w1c[3]) | set_frame;
         overrun   <= (overrun   & ~w1c[4]) | set_ovr;
         tx_done   <= (tx_done   & ~w1c[5]) | tx_end;

         if (rd) cfg_data_o <= rd_mux;
      end
   end

   assign rx_int_o  = rx_valid;
   assign tx_int_o  = tx_done;
   assign err_int_o = crc_err | frame_err | overrun;

endmodule

// File: tb/tb_uart_top.sv
// -----------------------------------------------------------------------------
// tb_uart_top
// Directed bench for uart_top. A short bit period (DIV=15, 16 clocks/bit)
// keeps frame times small. Expected RX words and TX bit streams are pushed
// to queues when stimulus is driven and popped when the DUT produces output.
// -----------------------------------------------------------------------------
module tb_uart_top;

   localparam int          BIT    = 16;
   localparam logic [15:0] DIV_TB = 16'd15;
   localparam logic [15:0] DIV_RV = 16'd10416;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        rx_i;
   logic        tx_o;
   logic        rx_int_o, tx_int_o, err_int_o;
   logic        cfg_we, cfg_cs;
   logic [31:0] cfg_data_i, cfg_data_o;
   logic [4:0]  cfg_addr_i;

   uart_top dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .rx_i       (rx_i),
      .tx_o       (tx_o),
      .rx_int_o   (rx_int_o),
      .tx_int_o   (tx_int_o),
      .err_int_o  (err_int_o),
      .cfg_we     (cfg_we),
      .cfg_cs     (cfg_cs),
      .cfg_data_i (cfg_data_i),
      .cfg_data_o (cfg_data_o),
      .cfg_addr_i (cfg_addr_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] crc;
      logic [7:0] data;
   } rx_exp_t;

   rx_exp_t rx_q[$];
   logic    tx_q[$];

   // Byte-wise CRC-8 (poly 0x07, init 0).
   function automatic logic [7:0] model_crc8(input logic [7:0] d);
      logic [7:0] c;
      c = d;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
         else      c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr_i = a; cfg_data_i = d;
      idle(1);
      cfg_cs = 1'b0; cfg_we = 1'b0; cfg_data_i = '0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      cfg_cs = 1'b1; cfg_we = 1'b0; cfg_addr_i = a;
      idle(1);
      cfg_cs = 1'b0;
      d = cfg_data_o;
   endtask

   task automatic send_rx(input logic [7:0] d, input logic [7:0] c,
                          input logic stop_bit);
      logic [17:0] fr;
      fr = {stop_bit, c, d, 1'b0};
      for (int i = 0; i < 18; i++) begin
         rx_i = fr[i];
         idle(BIT);
      end
      rx_i = 1'b1;
      idle(4);
   endtask

   task automatic wait_rx(input string tag);
      int n;
      n = 0;
      while (!rx_int_o && n < 2000) begin
         idle(1);
         n++;
      end
      check(tag, {31'd0, rx_int_o}, 32'd1);
   endtask

   task automatic pop_rx_and_read(input string tag);
      logic [31:0] r;
      rx_exp_t     e;
      bus_read(5'h03, r);
      e = rx_q.pop_front();
      check(tag, r, {16'd0, e});
   endtask

   // Sends one TX frame and compares tx_o at each mid-bit. With poke set,
   // a TX_DATA write and a CMD write are issued mid-frame; neither may
   // disturb the frame in flight.
   task automatic tx_frame(input string tag, input logic [7:0] d,
                           input logic crc_on, input logic poke);
      logic [7:0] c;
      logic       b;
      c = crc_on ? model_crc8(d) : 8'h00;
      tx_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) tx_q.push_back(d[i]);
      for (int i = 0; i < 8; i++) tx_q.push_back(c[i]);
      tx_q.push_back(1'b1);
      bus_write(5'h02, {24'd0, d});
      bus_write(5'h01, 32'd1);
      idle(BIT / 2);
      for (int k = 0; k < 18; k++) begin
         b = tx_q.pop_front();
         check($sformatf("%s_bit%0d", tag, k), {31'd0, tx_o}, {31'd0, b});
         if (k < 17) begin
            if (poke && k == 3) begin
               bus_write(5'h02, 32'h0000_00FF);
               bus_write(5'h01, 32'd1);
               idle(BIT - 2);
            end else begin
               idle(BIT);
            end
         end
      end
      idle(BIT);
      check({tag, "_tx_int"}, {31'd0, tx_int_o}, 32'd1);
      check({tag, "_idle"}, {31'd0, tx_o}, 32'd1);
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  c55;

      rst_i = 1'b1; rx_i = 1'b1; cfg_cs = 1'b0; cfg_we = 1'b0;
      cfg_addr_i = '0; cfg_data_i = '0;
      idle(3);

      // Reset state
      check("rst_tx_o", {31'd0, tx_o}, 32'd1);
      check("rst_ints", {29'd0, rx_int_o, tx_int_o, err_int_o}, 32'd0);
      check("rst_rdata", cfg_data_o, 32'd0);
      rst_i = 1'b0;
      idle(1);
      bus_read(5'h00, r);
      check("rst_cfg", r, {DIV_RV, 16'd0});
      bus_read(5'h04, r);
      check("rst_status", r, 32'd0);

      bus_write(5'h00, {DIV_TB, 16'h0007});
      bus_read(5'h00, r);
      check("cfg_rb", r, {DIV_TB, 16'h0007});

      // Good RX frame
      c55 = model_crc8(8'h55);
      rx_q.push_back('{crc: c55, data: 8'h55});
      send_rx(8'h55, c55, 1'b1);
      wait_rx("rx1_wait");
      check("rx1_err", {31'd0, err_int_o}, 32'd0);
      pop_rx_and_read("rx1_data");
      check("rx1_int_clr", {31'd0, rx_int_o}, 32'd0);

      // Bad CRC
      rx_q.push_back('{crc: model_crc8(8'h01) ^ 8'h01, data: 8'h01});
      send_rx(8'h01, model_crc8(8'h01) ^ 8'h01, 1'b1);
      wait_rx("rx2_wait");
      bus_read(5'h04, r);
      check("rx2_crc_err", r & 32'h1D, 32'h05);
      check("rx2_err_int", {31'd0, err_int_o}, 32'd1);
      pop_rx_and_read("rx2_data");
      bus_write(5'h04, 32'h04);
      check("rx2_err_clr", {31'd0, err_int_o}, 32'd0);

      // Frame error
      rx_q.push_back('{crc: model_crc8(8'h96), data: 8'h96});
      send_rx(8'h96, model_crc8(8'h96), 1'b0);
      wait_rx("rx3_wait");
      bus_read(5'h04, r);
      check("rx3_frame_err", r & 32'h1D, 32'h09);
      pop_rx_and_read("rx3_data");
      bus_write(5'h04, 32'h08);
      check("rx3_err_clr", {31'd0, err_int_o}, 32'd0);

      // Overrun: second byte overwrites the first
      send_rx(8'hA3, model_crc8(8'hA3), 1'b1);
      rx_q.push_back('{crc: model_crc8(8'h3C), data: 8'h3C});
      send_rx(8'h3C, model_crc8(8'h3C), 1'b1);
      wait_rx("rx4_wait");
      bus_read(5'h04, r);
      check("rx4_overrun", r & 32'h1D, 32'h11);
      pop_rx_and_read("rx4_data");
      bus_write(5'h04, 32'h10);
      check("rx4_err_clr", {31'd0, err_int_o}, 32'd0);

      // TX with CRC
      tx_frame("tx1", 8'h55, 1'b1, 1'b0);
      bus_write(5'h04, 32'h20);
      check("tx1_done_clr", {31'd0, tx_int_o}, 32'd0);

      // TX with CRC disabled and mid-frame writes ignored
      bus_write(5'h00, {DIV_TB, 16'h0003});
      tx_frame("tx2", 8'hC3, 1'b0, 1'b1);
      bus_write(5'h04, 32'h20);

      // Glitch on idle RX line
      rx_i = 1'b0;
      idle(1);
      rx_i = 1'b1;
      idle(3 * BIT);
      bus_read(5'h04, r);
      check("glitch_status", r, 32'd0);

      // Reset in the middle of a TX frame
      bus_write(5'h02, 32'h0000_00A5);
      bus_write(5'h01, 32'd1);
      idle(40);
      bus_read(5'h04, r);
      check("mid_tx_busy", r & 32'h02, 32'h02);
      idle(10);
      rst_i = 1'b1;
      idle(1);
      check("rst_mid_tx_o", {31'd0, tx_o}, 32'd1);
      rst_i = 1'b0;
      bus_read(5'h04, r);
      check("rst_mid_status", r, 32'd0);
      bus_read(5'h00, r);
      check("rst_mid_cfg", r, {DIV_RV, 16'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
